// File: rtl/hssi_ss_ready_latency_adapter_pkg.sv
// Shared constants and elaboration helpers for the HSSI ready-latency adapter.
package hssi_ss_ready_latency_adapter_pkg;

    localparam int HSSI_SS_MAX_READY_LATENCY = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit params_ok(input int latency, input int depth);
        return (latency >= 0) && (latency <= HSSI_SS_MAX_READY_LATENCY)
            && (depth >= latency + 1);
    endfunction

endpackage

// File: rtl/hssi_ss_ready_latency_adapter_if.sv
// Upstream (ready-latency N) and downstream (ready-latency 0) handshake bundle.
interface hssi_ss_ready_latency_adapter_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/hssi_ss_rl_fifo.sv
// Show-ahead register-array FIFO; pointers wrap by compare so DEPTH may be any size.
module hssi_ss_rl_fifo
    import hssi_ss_ready_latency_adapter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        out_valid,
    output logic [clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int OW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            occupancy <= occupancy + OW'(wr) - OW'(pop);
        end
    end

    assign out_valid = (occupancy != '0);
    assign rd_data   = mem[rd_ptr];

endmodule

// File: rtl/hssi_ss_ready_latency_adapter.sv
// Ready-latency N to 0 adapter: registered upstream grant, reservation-based
// backpressure so every granted beat always has a free buffer slot.
module hssi_ss_ready_latency_adapter
    import hssi_ss_ready_latency_adapter_pkg::*;
#(
    parameter int WIDTH         = 64,
    parameter int READY_LATENCY = 3,
    parameter int DEPTH         = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    hssi_ss_ready_latency_adapter_if.slave bus,
    output logic [clog2(DEPTH+1)-1:0]   occupancy,
    output logic                        proto_err
);
    localparam int OW = clog2(DEPTH + 1);

    if (!params_ok(READY_LATENCY, DEPTH)) begin : g_bad_params
        $error("hssi_ss_ready_latency_adapter: illegal READY_LATENCY/DEPTH");
    end

    logic          matured;
    logic          wr;
    logic          pop;
    logic          release_grant;
    logic [OW-1:0] resv;
    logic [OW-1:0] resv_next;

    if (READY_LATENCY == 0) begin : g_rl0
        assign matured = bus.in_ready;
    end else begin : g_grant_sr
        logic [READY_LATENCY-1:0] grant_sr;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grant_sr <= '0;
            end else begin
                grant_sr <= (grant_sr << 1) | READY_LATENCY'(bus.in_ready);
            end
        end
        assign matured = grant_sr[READY_LATENCY-1];
    end

    assign wr            = bus.in_valid & matured;
    assign pop           = bus.out_valid & bus.out_ready;
    // An unused matured grant hands its reserved slot back.
    assign release_grant = matured & ~bus.in_valid;

    always_comb begin
        resv_next = resv + OW'(bus.in_ready) - OW'(pop) - OW'(release_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resv         <= '0;
            bus.in_ready <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            resv         <= resv_next;
            bus.in_ready <= (resv_next < OW'(DEPTH));
            if (bus.in_valid & ~matured) begin
                proto_err <= 1'b1;
            end
        end
    end

    hssi_ss_rl_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .wr_data   (bus.in_data),
        .pop       (pop),
        .rd_data   (bus.out_data),
        .out_valid (bus.out_valid),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_hssi_ss_ready_latency_adapter.sv
// Bench for the ready-latency adapter: per-cycle vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_hssi_ss_ready_latency_adapter;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [3:0] occ_a;
    logic [1:0] occ_b;
    logic       pe_a;
    logic       pe_b;

    hssi_ss_ready_latency_adapter_if #(.WIDTH(W)) a_if();
    hssi_ss_ready_latency_adapter_if #(.WIDTH(W)) b_if();

    hssi_ss_ready_latency_adapter #(
        .WIDTH(W), .READY_LATENCY(3), .DEPTH(8)
    ) dut_a (
        .clk(clk), .rst(rst_a), .bus(a_if.slave),
        .occupancy(occ_a), .proto_err(pe_a)
    );

    hssi_ss_ready_latency_adapter #(
        .WIDTH(W), .READY_LATENCY(0), .DEPTH(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(b_if.slave),
        .occupancy(occ_b), .proto_err(pe_b)
    );

    int errors = 0;
    int checks = 0;

    // model state
    int           sel;
    int           rl;
    int           depth;
    int           q[$];
    bit           hist[$];
    bit           exp_ir;
    bit           exp_pe;
    int           dmax;
    int           pops;
    int           first_pop;
    int           last_pop;
    int           cyc = 0;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        o;
        logic        ir;
        logic        ov;
        logic [3:0]  occ;
        logic [15:0] od;
        logic        pe;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic f_ir();
        return sel != 0 ? b_if.in_ready : a_if.in_ready;
    endfunction
    function automatic logic f_ov();
        return sel != 0 ? b_if.out_valid : a_if.out_valid;
    endfunction
    function automatic logic [W-1:0] f_od();
        return sel != 0 ? b_if.out_data : a_if.out_data;
    endfunction
    function automatic int f_occ();
        return sel != 0 ? int'(occ_b) : int'(occ_a);
    endfunction
    function automatic logic f_pe();
        return sel != 0 ? pe_b : pe_a;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input logic o);
        a_if.in_valid  = (sel == 0) ? v : 1'b0;
        a_if.in_data   = (sel == 0) ? d : '0;
        a_if.out_ready = (sel == 0) ? o : 1'b0;
        b_if.in_valid  = (sel != 0) ? v : 1'b0;
        b_if.in_data   = (sel != 0) ? d : '0;
        b_if.out_ready = (sel != 0) ? o : 1'b0;
    endtask

    function automatic bit matured_now();
        int t;
        t = hist.size();
        if (rl == 0) return f_ir();
        return (t >= rl) ? hist[t-rl] : 1'b0;
    endfunction

    task automatic model_clear();
        q.delete();
        hist.delete();
        exp_ir = 1'b0;
        exp_pe = 1'b0;
    endtask

    task automatic do_reset(input int s);
        sel = s;
        drive(1'b0, '0, 1'b0);
        if (s != 0) rst_b = 1'b1; else rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (s != 0) rst_b = 1'b0; else rst_a = 1'b0;
        model_clear();
    endtask

    // One cycle against the reference model; entered and left at posedge+1.
    task automatic step(input logic v, input logic [W-1:0] d, input logic o);
        int  t;
        int  outstanding;
        bit  ir;
        bit  mat;
        bit  pop;
        drive(v, d, o);
        @(negedge clk);
        t  = hist.size();
        ir = f_ir();
        chk("in_ready", ir, exp_ir);
        chk("out_valid", f_ov(), q.size() != 0);
        chk("occupancy", f_occ(), q.size());
        chk("proto_err", f_pe(), exp_pe);
        if (q.size() != 0) chk("out_data", f_od(), q[0]);
        if (f_occ() > dmax) dmax = f_occ();
        mat = (rl == 0) ? ir : ((t >= rl) ? hist[t-rl] : 1'b0);
        if (v && mat) chk("no_overflow_write", f_occ() < depth, 1);
        pop = (q.size() != 0) && o;
        if (pop) begin
            void'(q.pop_front());
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (v && mat) q.push_back(int'(d));
        if (v && !mat) exp_pe = 1'b1;
        hist.push_back(ir);
        outstanding = 0;
        for (int k = t - rl + 1; k <= t; k++) begin
            if (rl > 0 && k >= 0) outstanding += int'(hist[k]);
        end
        exp_ir = (q.size() + outstanding) < depth;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // omode: 0 hold off, 1 always ready, 2 random ready and random valid
    task automatic run(input int n, input int base, input int omode,
                       input int cycles);
        int  sent;
        bit  v;
        bit  o;
        logic [W-1:0] d;
        sent = 0;
        for (int c = 0; c < cycles; c++) begin
            v = matured_now() && (sent < n);
            o = (omode == 1);
            d = W'(base + sent);
            if (omode == 2) begin
                o = ($urandom_range(1, 0) == 1);
                v = v && ($urandom_range(3, 0) != 0);
                d = W'($urandom);
            end
            if (v) sent++;
            step(v, d, o);
        end
    endtask

    initial begin
        // cycle-by-cycle vectors from reset release, latency 3, depth 8
        tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0};
        tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0};
        tbl[4] = '{1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0011, 1'b0};
        tbl[6] = '{1'b1, 16'h0022, 1'b0, 1'b1, 1'b1, 4'd1, 16'h0011, 1'b0};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0011, 1'b0};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd1, 16'h0022, 1'b0};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b0};

        sel = 0; rl = 3; depth = 8;
        dmax = 0; pops = 0; first_pop = -1; last_pop = -1;
        drive(1'b0, '0, 1'b0);
        sel = 1;
        drive(1'b0, '0, 1'b0);
        sel = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b0;
        chk("reset_in_ready", a_if.in_ready, 0);
        chk("reset_out_valid", a_if.out_valid, 0);
        chk("reset_occupancy", occ_a, 0);
        chk("reset_proto_err", pe_a, 0);
        rst_a = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].o);
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), a_if.in_ready, tbl[i].ir);
            chk($sformatf("tbl%0d_out_valid", i), a_if.out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_occupancy", i), occ_a, tbl[i].occ);
            chk($sformatf("tbl%0d_proto_err", i), pe_a, tbl[i].pe);
            if (tbl[i].ov)
                chk($sformatf("tbl%0d_out_data", i), a_if.out_data, tbl[i].od);
            @(posedge clk);
            #1;
        end

        // streaming 0x01..0x14 at full rate
        do_reset(0);
        pops = 0; first_pop = -1;
        run(20, 1, 1, 30);
        chk("stream_beats", pops, 20);
        chk("stream_span", last_pop - first_pop + 1, 20);

        // backpressure until full, then drain and resume
        dmax = 0;
        run(20, 'h100, 0, 20);
        chk("bp_occ_full", dmax, 8);
        chk("bp_in_ready_low", a_if.in_ready, 0);
        run(20, 'h200, 1, 30);
        run(0, 0, 1, 12);

        // grants left unused
        run(0, 0, 1, 10);
        chk("unused_in_ready", a_if.in_ready, 1);

        // beat on a non-granted cycle is dropped, error is sticky
        do_reset(0);
        step(1'b0, '0, 1'b1);
        step(1'b1, 16'hDEAD, 1'b1);
        run(4, 'h55, 1, 14);
        chk("proto_sticky", pe_a, 1);
        do_reset(0);
        step(1'b0, '0, 1'b1);

        // reset in the middle of a burst with five beats buffered
        do_reset(0);
        for (int g = 0; g < 40 && q.size() < 5; g++) begin
            step(matured_now(), W'(16'h0300 + g), 1'b0);
        end
        chk("pre_rst_occupancy", occ_a, 5);
        rst_a = 1'b1;
        #2;
        chk("mid_rst_out_valid", a_if.out_valid, 0);
        chk("mid_rst_occupancy", occ_a, 0);
        chk("mid_rst_in_ready", a_if.in_ready, 0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        model_clear();
        pops = 0;
        run(8, 'hA0, 1, 25);
        chk("post_rst_beats", pops, 8);

        // random traffic, latency 3
        do_reset(0);
        run(1000, 0, 2, 300);
        run(0, 0, 1, 15);

        // random traffic, latency 0, depth 2
        rl = 0; depth = 2;
        do_reset(1);
        dmax = 0; pops = 0;
        run(1000, 0, 2, 300);
        run(0, 0, 1, 5);
        chk("rl0_occ_bound", dmax <= 2, 1);
        chk("rl0_traffic", pops > 50, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
